div_arbiter: RTL and testbench

Sequencer and 2-way arbiter that shares the single iterative 32-bit divider between the two issue pipes of the dual-issue core. Grants one requester at a time and registers its operands, which stay stable for the whole operation. Drives the divider's start/annul handshake and returns the 64-bit {remainder, quotient} result to the owning pipe. Sits in EX between both pipes' DIV/DIVU decode and the divider instance.

---
 rtl/div_arbiter_pkg.sv | 21 ++
 rtl/div_arbiter_rr_arb2.sv | 44 ++++
 rtl/div_arbiter.sv | 206 ++++++++++++++++++++
 tb/tb_div_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// div_arb_pkg
// Shared definitions for the divider arbiter: FSM state encoding and the fixed
// timing constants of the shared iterative divider.
// -----------------------------------------------------------------------------
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Cycles the divider start line is held low after an annul.
  localparam int DRAIN_CYCLES = 2;

  // Grant-to-result latency for a nonzero divisor.
  localparam int DIV_LAT = 36;

endpackage

// File: rtl/div_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. When both requesters are active the
// pointer picks the winner; a single active requester always wins.
// The pointer moves to the pipe opposite i_last whenever i_upd is high.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (pointer -> 0)
//   i_req[1:0]    request vector
//   i_upd         update pointer this cycle
//   i_last        id of the requester that was just served
//   o_gnt_valid   some requester is active
//   o_gnt_id      id of the winning requester
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_upd,
  input  logic       i_last,
  output logic       o_gnt_valid,
  output logic       o_gnt_id
);

  logic r_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (i_upd) begin
      r_ptr <= ~i_last;
    end
  end

  always_comb begin
    o_gnt_valid = |i_req;
    if (&i_req) begin
      o_gnt_id = r_ptr;
    end else begin
      o_gnt_id = i_req[1];
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// -----------------------------------------------------------------------------
// div_arbiter
// Shares one iterative divider between the two issue pipes. One requester is
// granted at a time; its operands are registered and held for the whole
// operation. The block drives the divider start/annul handshake and returns
// the {remainder, quotient} result to the owning pipe as a one-cycle strobe.
//
// Configuration macro: DIV_ZERO_BYPASS_EN
//   defined   : a zero divisor never starts the divider; result 0 is returned
//               one cycle after grant.
//   undefined : a zero divisor goes through the divider like any other.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   reqN_valid/signed/op1/op2/flush (N=0,1)  pipe N request
//   stallN                   pipe N must hold (request pending, no result yet)
//   resN_valid               one-cycle result strobe for pipe N
//   res_data                 {remainder, quotient}, held until next result
//   div_start/div_annul      divider handshake
//   div_signed/op1/op2       registered operands to the divider
//   div_result/div_ready     divider result interface
// -----------------------------------------------------------------------------
module div_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req0_valid,
  input  logic                req0_signed,
  input  logic [DATA_W-1:0]   req0_op1,
  input  logic [DATA_W-1:0]   req0_op2,
  input  logic                req0_flush,
  input  logic                req1_valid,
  input  logic                req1_signed,
  input  logic [DATA_W-1:0]   req1_op1,
  input  logic [DATA_W-1:0]   req1_op2,
  input  logic                req1_flush,
  output logic                stall0,
  output logic                stall1,
  output logic                res0_valid,
  output logic                res1_valid,
  output logic [2*DATA_W-1:0] res_data,
  output logic                div_start,
  output logic                div_annul,
  output logic                div_signed,
  output logic [DATA_W-1:0]   div_op1,
  output logic [DATA_W-1:0]   div_op2,
  input  logic [2*DATA_W-1:0] div_result,
  input  logic                div_ready
);
  import div_arb_pkg::*;

  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_t              r_state;
  state_t              w_next;

  logic [1:0]          w_elig;
  logic                w_gnt_valid;
  logic                w_gnt_id;
  logic                w_gnt_signed;
  logic [DATA_W-1:0]   w_gnt_op1;
  logic [DATA_W-1:0]   w_gnt_op2;
  logic                w_zero_bypass;
  logic                w_owner_flush;

  logic                w_grant;
  logic                w_capture;
  logic                w_abort;
  logic                w_bypass;
  logic                w_rr_upd;

  logic                r_owner;
  logic                r_signed;
  logic [DATA_W-1:0]   r_op1;
  logic [DATA_W-1:0]   r_op2;
  logic [2*DATA_W-1:0] r_res_data;
  logic [1:0]          r_res_vld;
  logic                r_annul;
  logic [1:0]          r_drain_cnt;

  // A pipe flushing this cycle is never eligible, even with valid high.
  assign w_elig = {req1_valid & ~req1_flush, req0_valid & ~req0_flush};

  rr_arb2 u_rr (
    .clk         (clk),
    .rst         (rst),
    .i_req       (w_elig),
    .i_upd       (w_rr_upd),
    .i_last      (r_owner),
    .o_gnt_valid (w_gnt_valid),
    .o_gnt_id    (w_gnt_id)
  );

  assign w_gnt_signed  = w_gnt_id ? req1_signed : req0_signed;
  assign w_gnt_op1     = w_gnt_id ? req1_op1    : req0_op1;
  assign w_gnt_op2     = w_gnt_id ? req1_op2    : req0_op2;
  assign w_owner_flush = r_owner  ? req1_flush  : req0_flush;

`ifdef DIV_ZERO_BYPASS_EN
  assign w_zero_bypass = (w_gnt_op2 == '0);
`else
  assign w_zero_bypass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    w_capture = 1'b0;
    w_abort   = 1'b0;
    w_bypass  = 1'b0;
    w_rr_upd  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_gnt_valid) begin
          w_grant = 1'b1;
          if (w_zero_bypass) begin
            w_bypass = 1'b1;
            w_next   = DONE;
          end else begin
            w_next   = BUSY;
          end
        end
      end
      BUSY: begin
        // Flush beats a simultaneous div_ready: the result is dropped.
        if (w_owner_flush) begin
          w_abort = 1'b1;
          w_next  = DRAIN;
        end else if (div_ready) begin
          w_capture = 1'b1;
          w_next    = DONE;
        end
      end
      DONE: begin
        // One idle cycle with start low so the divider can return to free.
        w_rr_upd = 1'b1;
        w_next   = IDLE;
      end
      DRAIN: begin
        // Start stays low long enough for a divider stuck in its
        // divide-by-zero path to fall back to idle.
        if (r_drain_cnt == DRAIN_LAST) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner     <= 1'b0;
      r_signed    <= 1'b0;
      r_op1       <= '0;
      r_op2       <= '0;
      r_res_data  <= '0;
      r_res_vld   <= 2'b00;
      r_annul     <= 1'b0;
      r_drain_cnt <= 2'd0;
    end else begin
      r_res_vld <= 2'b00;
      r_annul   <= 1'b0;
      if (w_grant) begin
        r_owner  <= w_gnt_id;
        r_signed <= w_gnt_signed;
        r_op1    <= w_gnt_op1;
        r_op2    <= w_gnt_op2;
      end
      if (w_capture) begin
        r_res_data          <= div_result;
        r_res_vld[r_owner]  <= 1'b1;
      end
      if (w_bypass) begin
        r_res_data          <= '0;
        r_res_vld[w_gnt_id] <= 1'b1;
      end
      if (w_abort) begin
        r_annul     <= 1'b1;
        r_drain_cnt <= 2'd0;
      end else if (r_state == DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 2'd1;
      end
    end
  end

  assign div_start  = (r_state == BUSY);
  assign div_annul  = r_annul;
  assign div_signed = r_signed;
  assign div_op1    = r_op1;
  assign div_op2    = r_op2;
  assign res_data   = r_res_data;
  assign res0_valid = r_res_vld[0];
  assign res1_valid = r_res_vld[1];
  assign stall0     = req0_valid & ~r_res_vld[0];
  assign stall1     = req1_valid & ~r_res_vld[1];

endmodule

// File: tb/tb_div_arbiter.sv
// -----------------------------------------------------------------------------
// tb_div_arbiter
// Self-checking bench for div_arbiter. Contains a behavioural model of the
// shared divider (start/annul/ready handshake) and a transaction-level
// reference: expected result by plain arithmetic, expected latency by the
// documented timing, expected winner by "the pipe not served last".
// -----------------------------------------------------------------------------
module tb_div_arbiter;
  import div_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_signed, req0_flush;
  logic        req1_valid, req1_signed, req1_flush;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic        stall0, stall1, res0_valid, res1_valid;
  logic [63:0] res_data;
  logic        div_start, div_annul, div_signed;
  logic [31:0] div_op1, div_op2;
  logic [63:0] div_result;
  logic        div_ready;

  int total = 0;
  int bad   = 0;
  int m_pref = 0;   // pipe that wins when both are eligible
  logic [63:0] last_data;

  always #5 clk = ~clk;

  div_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_signed(req0_signed), .req0_op1(req0_op1),
    .req0_op2(req0_op2), .req0_flush(req0_flush),
    .req1_valid(req1_valid), .req1_signed(req1_signed), .req1_op1(req1_op1),
    .req1_op2(req1_op2), .req1_flush(req1_flush),
    .stall0(stall0), .stall1(stall1), .res0_valid(res0_valid), .res1_valid(res1_valid),
    .res_data(res_data), .div_start(div_start), .div_annul(div_annul),
    .div_signed(div_signed), .div_op1(div_op1), .div_op2(div_op2),
    .div_result(div_result), .div_ready(div_ready)
  );

  function automatic logic [63:0] ref_div(input logic sg, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = a;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [63:0] exp_res(input logic sg, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_ZERO_BYPASS_EN
    if (b == 32'd0) return 64'd0;
`endif
    return ref_div(sg, a, b);
  endfunction

  // Clock edges from presenting a request (arbiter idle) to the result strobe.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_BYPASS_EN
    if (b == 32'd0) return 1;
`else
    if (b == 32'd0) return 5;
`endif
    return DIV_LAT + 1;
  endfunction

  // Behavioural divider: ready 35 cycles after it sees start (3 for b == 0),
  // holds ready while start stays high, drops everything on annul/stop/rst.
  logic        dv_busy;
  int          dv_cnt, dv_target;
  logic [63:0] dv_res;
  always @(posedge clk) begin
    if (rst || !div_start || div_annul) begin
      dv_busy    <= 1'b0;
      div_ready  <= 1'b0;
      dv_cnt     <= 0;
      div_result <= 64'd0;
    end else if (!dv_busy) begin
      dv_busy   <= 1'b1;
      dv_cnt    <= 1;
      dv_target <= (div_op2 == 32'd0) ? 3 : DIV_LAT - 1;
      dv_res    <= ref_div(div_signed, div_op1, div_op2);
    end else if (!div_ready) begin
      dv_cnt <= dv_cnt + 1;
      if (dv_cnt + 1 == dv_target) begin
        div_ready  <= 1'b1;
        div_result <= dv_res;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic sg,
                         input logic [31:0] a, input logic [31:0] b);
    if (p == 0) begin
      req0_valid = v; req0_signed = sg; req0_op1 = a; req0_op2 = b;
    end else begin
      req1_valid = v; req1_signed = sg; req1_op1 = a; req1_op2 = b;
    end
    #1;
  endtask

  task automatic drop(input int p);
    if (p == 0) req0_valid = 1'b0;
    else        req1_valid = 1'b0;
  endtask

  // Waits for a result strobe; pipe = -1 on timeout, 2 if both strobe.
  task automatic wait_any(input int max, output int pipe, output logic [63:0] data,
                          output int n, output logic saw_start);
    pipe = -1; n = 0; saw_start = 1'b0; data = 64'd0;
    while (n < max) begin
      tick();
      n++;
      if (div_start) saw_start = 1'b1;
      if (res0_valid || res1_valid) begin
        pipe = (res0_valid && res1_valid) ? 2 : (res0_valid ? 0 : 1);
        data = res_data;
        break;
      end
    end
  endtask

  task automatic run_single(input string tag, input int p, input logic sg,
                            input logic [31:0] a, input logic [31:0] b);
    int gp, n;
    logic [63:0] d;
    logic ss;
    set_req(p, 1'b1, sg, a, b);
    chk($sformatf("%s_stall_wait", tag), (p == 0) ? stall0 : stall1, 1'b1);
    wait_any(60, gp, d, n, ss);
    chk($sformatf("%s_pipe", tag), gp, p);
    chk($sformatf("%s_lat", tag), n, exp_lat(b));
    chk($sformatf("%s_data", tag), d, exp_res(sg, a, b));
    chk($sformatf("%s_stall_res", tag), (p == 0) ? stall0 : stall1, 1'b0);
`ifdef DIV_ZERO_BYPASS_EN
    if (b == 32'd0) chk($sformatf("%s_nostart", tag), ss, 1'b0);
`endif
    last_data = d;
    drop(p);
    m_pref = 1 - p;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_pref = 0;
  endtask

  initial begin
    int gp, n, ow, ot, k;
    logic [63:0] d, e0, e1;
    logic ss, sg0, sg1;
    logic [31:0] a0, b0, a1, b1;

    rst = 1'b1;
    req0_valid = 0; req0_signed = 0; req0_op1 = 0; req0_op2 = 0; req0_flush = 0;
    req1_valid = 0; req1_signed = 0; req1_op1 = 0; req1_op2 = 0; req1_flush = 0;
    tick(); tick(); tick();
    chk("rst_start", div_start, 1'b0);
    chk("rst_annul", div_annul, 1'b0);
    chk("rst_res0", res0_valid, 1'b0);
    chk("rst_res1", res1_valid, 1'b0);
    chk("rst_data", res_data, 64'd0);
    chk("rst_op1", div_op1, 32'd0);
    chk("rst_stall0", stall0, 1'b0);
    rst = 1'b0;

    // Single signed divide on pipe 0.
    run_single("div100_7", 0, 1'b1, 32'd100, 32'd7);
    chk("div100_7_const", last_data, {32'd2, 32'd14});
    tick(); tick();
    chk("res_hold", res_data, {32'd2, 32'd14});

    // Simultaneous pair from a fresh pointer; pipe 0 reissues during DONE.
    do_reset();
    req0_valid = 1; req0_signed = 0; req0_op1 = 32'hFFFF_FFFF; req0_op2 = 32'd16;
    req1_valid = 1; req1_signed = 1; req1_op1 = -32'sd20;      req1_op2 = 32'd3;
    wait_any(60, gp, d, n, ss);
    chk("pair1_pipe", gp, m_pref);
    chk("pair1_lat", n, DIV_LAT + 1);
    chk("pair1_data", d, {32'h0000_000F, 32'h0FFF_FFFF});
    m_pref = 1;
    req0_signed = 0; req0_op1 = 32'd1000; req0_op2 = 32'd10;
    wait_any(60, gp, d, n, ss);
    chk("pair2_pipe", gp, m_pref);
    chk("pair2_lat", n, DIV_LAT + 2);
    chk("pair2_data", d, {32'hFFFF_FFFE, 32'hFFFF_FFFA});
    drop(1);
    m_pref = 0;
    wait_any(60, gp, d, n, ss);
    chk("pair3_pipe", gp, m_pref);
    chk("pair3_lat", n, DIV_LAT + 2);
    chk("pair3_data", d, {32'd0, 32'd100});
    drop(0);
    m_pref = 1;
    tick();

    // Owner flush 10 cycles into BUSY while the other pipe waits.
    ow = m_pref; ot = 1 - m_pref;
    set_req(ow, 1'b1, 1'b1, 32'd500, 32'd5);
    set_req(ot, 1'b1, 1'b0, 32'd12345, 32'd11);
    tick();
    chk("fl_start", div_start, 1'b1);
    chk("fl_op1", div_op1, 32'd500);
    for (int i = 0; i < 10; i++) tick();
    if (ow == 0) begin req0_flush = 1; req0_valid = 0; end
    else         begin req1_flush = 1; req1_valid = 0; end
    tick();
    req0_flush = 0; req1_flush = 0;
    chk("fl_annul_hi", div_annul, 1'b1);
    chk("fl_start_lo", div_start, 1'b0);
    chk("fl_nores_a", {res0_valid, res1_valid}, 2'b00);
    tick();
    chk("fl_annul_lo", div_annul, 1'b0);
    chk("fl_drain1", div_start, 1'b0);
    tick();
    chk("fl_drain2", div_start, 1'b0);
    chk("fl_nores_b", {res0_valid, res1_valid}, 2'b00);
    tick();
    chk("fl_regrant", div_start, 1'b1);
    chk("fl_regrant_op2", div_op2, 32'd11);
    wait_any(60, gp, d, n, ss);
    chk("fl_other_pipe", gp, ot);
    chk("fl_other_lat", n, DIV_LAT);
    chk("fl_other_data", d, ref_div(1'b0, 32'd12345, 32'd11));
    drop(ot);
    m_pref = ow;
    tick();

    // Flush in the same cycle div_ready is high.
    set_req(0, 1'b1, 1'b1, 32'd9, 32'd2);
    k = 0;
    while (k < 50 && div_ready !== 1'b1) begin tick(); k++; end
    chk("fr_ready_seen", div_ready, 1'b1);
    req0_flush = 1; req0_valid = 0;
    tick();
    req0_flush = 0;
    chk("fr_nores", res0_valid, 1'b0);
    chk("fr_annul", div_annul, 1'b1);
    chk("fr_start", div_start, 1'b0);
    tick(); tick();
    chk("fr_nores_late", {res0_valid, res1_valid}, 2'b00);
    tick();

    // Zero divisor.
    run_single("zero", 1, 1'b0, 32'd55, 32'd0);
`ifdef DIV_ZERO_BYPASS_EN
    chk("zero_const", last_data, 64'd0);
`else
    chk("zero_const", last_data, {32'd55, 32'hFFFF_FFFF});
`endif

    // Reset in the middle of BUSY, request kept valid.
    set_req(1, 1'b1, 1'b1, -32'sd100, 32'd9);
    for (int i = 0; i < 11; i++) tick();
    rst = 1'b1;
    tick();
    chk("mrst_start", div_start, 1'b0);
    chk("mrst_stall1", stall1, 1'b1);
    chk("mrst_res1", res1_valid, 1'b0);
    rst = 1'b0;
    m_pref = 0;
    wait_any(60, gp, d, n, ss);
    chk("mrst_pipe", gp, 1);
    chk("mrst_lat", n, DIV_LAT + 1);
    chk("mrst_data", d, {-32'sd1, -32'sd11});
    drop(1);
    m_pref = 0;
    tick();

    // Random single requests.
    for (int i = 0; i < 8; i++) begin
      int p;
      p   = $urandom_range(0, 1);
      sg0 = 1'($urandom_range(0, 1));
      a0  = $urandom;
      case ($urandom_range(0, 3))
        0:       b0 = 32'd0;
        1:       b0 = $urandom;
        default: b0 = $urandom_range(1, 50);
      endcase
      run_single($sformatf("rnd%0d", i), p, sg0, a0, b0);
    end

    // Random simultaneous pairs.
    for (int i = 0; i < 4; i++) begin
      sg0 = 1'($urandom_range(0, 1)); a0 = $urandom; b0 = $urandom_range(1, 1000);
      sg1 = 1'($urandom_range(0, 1)); a1 = $urandom; b1 = $urandom | 32'd1;
      e0 = ref_div(sg0, a0, b0);
      e1 = ref_div(sg1, a1, b1);
      req0_valid = 1; req0_signed = sg0; req0_op1 = a0; req0_op2 = b0;
      req1_valid = 1; req1_signed = sg1; req1_op1 = a1; req1_op2 = b1;
      ow = m_pref;
      wait_any(60, gp, d, n, ss);
      chk($sformatf("rp%0d_first_pipe", i), gp, ow);
      chk($sformatf("rp%0d_first_data", i), d, (ow == 0) ? e0 : e1);
      drop(ow);
      m_pref = 1 - ow;
      wait_any(60, gp, d, n, ss);
      chk($sformatf("rp%0d_second_pipe", i), gp, 1 - ow);
      chk($sformatf("rp%0d_second_lat", i), n, DIV_LAT + 2);
      chk($sformatf("rp%0d_second_data", i), d, (ow == 0) ? e1 : e0);
      drop(1 - ow);
      m_pref = ow;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
